// File: rtl/sdram_port_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Package : sdram_arb_pkg
// Brief   : Shared state encoding and width defaults for the SDRAM port arbiter.
// Rev     : 1.0
// ============================================================================
package sdram_arb_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_BSY  = 2'd2,
        WAIT_DONE = 2'd3
    } arb_state_t;

    localparam int DEF_ADDR_W = 25;
    localparam int DEF_DATA_W = 16;

endpackage
`default_nettype wire

// File: rtl/sdram_port_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
// Module : rr_pick
// Brief  : Combinational round-robin picker; first set request at/after ptr.
// Rev    : 1.0
// ============================================================================
module rr_pick #(
    parameter int N  = 2,
    parameter int PW = 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic          any,
    output logic [PW-1:0] idx
);

    logic [PW-1:0] cand;

    // Scan from the farthest offset down so the nearest set bit overwrites last.
    always_comb begin
        any  = 1'b0;
        idx  = '0;
        cand = '0;
        for (int k = N - 1; k >= 0; k--) begin
            cand = PW'((int'(ptr) + k) % N);
            if (req[cand]) begin
                any = 1'b1;
                idx = cand;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/sdram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module : sdram_port_arbiter
// Brief  : Round-robin share of one SDRAM controller port, one access in flight.
// Rev    : 1.0
// ============================================================================
module sdram_port_arbiter
    import sdram_arb_pkg::*;
#(
    parameter int NUM_REQ  = 2,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int DATA_W   = DEF_DATA_W,
    parameter int BUSY_TMO = 15
) (
    input  logic                      clk50,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ-1:0]        req_we,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    output logic [NUM_REQ-1:0]        gnt,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [DATA_W-1:0]         rsp_data,
    output logic                      err,
    output logic                      read,
    output logic                      write,
    output logic [ADDR_W-1:0]         addr,
    output logic [DATA_W-1:0]         wdata,
    input  logic                      busy,
    input  logic                      read_ready,
    input  logic [DATA_W-1:0]         rdata
);

    localparam int PTR_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(BUSY_TMO + 1);

    logic [ADDR_W-1:0] addr_arr  [NUM_REQ];
    logic [DATA_W-1:0] wdata_arr [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign addr_arr[g]  = req_addr[g*ADDR_W +: ADDR_W];
        assign wdata_arr[g] = req_wdata[g*DATA_W +: DATA_W];
    end

    arb_state_t         state_q, state_d;
    logic [PTR_W-1:0]   ptr_q, ptr_d;
    logic [PTR_W-1:0]   idx_q, idx_d;
    logic               we_q, we_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [DATA_W-1:0]  wdata_q, wdata_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               seen_q, seen_d;
    logic [DATA_W-1:0]  cap_q, cap_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    logic [NUM_REQ-1:0] rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]  rsp_data_q, rsp_data_d;
    logic               err_q, err_d;
    logic               read_q, read_d;
    logic               write_q, write_d;

    logic               pick_any;
    logic [PTR_W-1:0]   pick_idx;

    rr_pick #(
        .N  (NUM_REQ),
        .PW (PTR_W)
    ) u_rr_pick (
        .req (req),
        .ptr (ptr_q),
        .any (pick_any),
        .idx (pick_idx)
    );

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        idx_d       = idx_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        cnt_d       = cnt_q;
        seen_d      = seen_q;
        cap_d       = cap_q;
        rsp_data_d  = rsp_data_q;
        err_d       = err_q;
        gnt_d       = '0;
        rsp_valid_d = '0;
        read_d      = 1'b0;
        write_d     = 1'b0;

        case (state_q)
            IDLE: begin
                // A controller still busy from elsewhere blocks the next command.
                if (pick_any && !busy) begin
                    idx_d   = pick_idx;
                    we_d    = req_we[pick_idx];
                    addr_d  = addr_arr[pick_idx];
                    wdata_d = wdata_arr[pick_idx];
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                read_d       = ~we_q;
                write_d      = we_q;
                gnt_d[idx_q] = 1'b1;
                ptr_d        = (int'(idx_q) == NUM_REQ - 1) ? '0 : idx_q + PTR_W'(1);
                cnt_d        = '0;
                seen_d       = 1'b0;
                state_d      = WAIT_BSY;
            end
            WAIT_BSY: begin
                if (busy) begin
                    state_d = WAIT_DONE;
                end else if (cnt_q == CNT_W'(BUSY_TMO - 1)) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            WAIT_DONE: begin
                if (!we_q && read_ready && !seen_q) begin
                    seen_d = 1'b1;
                    cap_d  = rdata;
                end
                if (!busy) begin
                    state_d = IDLE;
                    if (!we_q) begin
                        rsp_valid_d[idx_q] = 1'b1;
                        if (seen_q) begin
                            rsp_data_d = cap_q;
                        end else if (read_ready) begin
                            rsp_data_d = rdata;
                        end else begin
                            rsp_data_d = '0;
                            err_d      = 1'b1;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk50) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            idx_q       <= '0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            cnt_q       <= '0;
            seen_q      <= 1'b0;
            cap_q       <= '0;
            gnt_q       <= '0;
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
            err_q       <= 1'b0;
            read_q      <= 1'b0;
            write_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            idx_q       <= idx_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            cnt_q       <= cnt_d;
            seen_q      <= seen_d;
            cap_q       <= cap_d;
            gnt_q       <= gnt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            err_q       <= err_d;
            read_q      <= read_d;
            write_q     <= write_d;
        end
    end

    assign gnt       = gnt_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign err       = err_q;
    assign read      = read_q;
    assign write     = write_q;
    assign addr      = addr_q;
    assign wdata     = wdata_q;

endmodule
`default_nettype wire

// File: tb/tb_sdram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module : tb_sdram_port_arbiter
// Brief  : Directed bench for sdram_port_arbiter with a small SDRAM controller model.
// Rev    : 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_sdram_port_arbiter;

    localparam int NR = 2;
    localparam int AW = 25;
    localparam int DW = 16;

    logic             clk50 = 1'b0;
    logic             rst_n;
    logic [NR-1:0]    req;
    logic [NR-1:0]    req_we;
    logic [NR*AW-1:0] req_addr;
    logic [NR*DW-1:0] req_wdata;
    logic [NR-1:0]    gnt;
    logic [NR-1:0]    rsp_valid;
    logic [DW-1:0]    rsp_data;
    logic             err;
    logic             read;
    logic             write;
    logic [AW-1:0]    addr;
    logic [DW-1:0]    wdata;
    logic             busy_w;
    logic             read_ready;
    logic [DW-1:0]    rdata;

    logic             mdl_busy;
    logic             stall_busy;
    logic             ctl_en;
    logic [DW-1:0]    rd_val;
    logic             was_rd;

    int n_tests = 0;
    int n_fail  = 0;
    int n_both  = 0;
    int n_long  = 0;
    int n_strb  = 0;
    int n_rsp   = 0;
    int gnt_log[$];
    logic prev_rd = 1'b0;
    logic prev_wr = 1'b0;

    assign busy_w = mdl_busy | stall_busy;

    always #10 clk50 = ~clk50;

    sdram_port_arbiter #(
        .NUM_REQ  (NR),
        .ADDR_W   (AW),
        .DATA_W   (DW),
        .BUSY_TMO (15)
    ) dut (
        .clk50      (clk50),
        .rst_n      (rst_n),
        .req        (req),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .gnt        (gnt),
        .rsp_valid  (rsp_valid),
        .rsp_data   (rsp_data),
        .err        (err),
        .read       (read),
        .write      (write),
        .addr       (addr),
        .wdata      (wdata),
        .busy       (busy_w),
        .read_ready (read_ready),
        .rdata      (rdata)
    );

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    // Controller model: busy for three cycles after a strobe, read_ready in the middle one.
    initial begin
        mdl_busy   = 1'b0;
        read_ready = 1'b0;
        rdata      = '0;
        forever begin
            @(posedge clk50); #1;
            if (ctl_en && (read || write)) begin
                was_rd   = read;
                mdl_busy = 1'b1;
                @(posedge clk50); #1;
                if (was_rd) begin
                    read_ready = 1'b1;
                    rdata      = rd_val;
                end
                @(posedge clk50); #1;
                read_ready = 1'b0;
                rdata      = '0;
                @(posedge clk50); #1;
                mdl_busy = 1'b0;
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk50); #3;
            if (read && write) n_both++;
            if ((read && prev_rd) || (write && prev_wr)) n_long++;
            prev_rd = read;
            prev_wr = write;
            if (read || write) n_strb++;
            if (|rsp_valid) n_rsp++;
            for (int c = 0; c < NR; c++) if (gnt[c]) gnt_log.push_back(c);
        end
    end

    task automatic set_req(input int c, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        req[c]                = 1'b1;
        req_we[c]             = we;
        req_addr[c*AW +: AW]  = a;
        req_wdata[c*DW +: DW] = d;
    endtask

    task automatic wait_gnt(input int c, input int budget, output int lat);
        lat = -1;
        for (int i = 1; i <= budget; i++) begin
            @(negedge clk50);
            if (gnt[c]) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic wait_rsp(input int budget, output int lat);
        lat = -1;
        for (int i = 1; i <= budget; i++) begin
            @(negedge clk50);
            if (|rsp_valid) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic check_reset_outs(input string tag);
        check_eq({tag, "_ctl"}, {gnt, rsp_valid, err, read, write}, '0);
        check_eq({tag, "_addr"}, addr, '0);
        check_eq({tag, "_wdata"}, wdata, '0);
        check_eq({tag, "_rdata"}, rsp_data, '0);
    endtask

    int lat;
    int base_rsp;
    int base_strb;
    int base_both;
    int base_long;
    int base_gnt;

    initial begin
        rst_n      = 1'b0;
        req        = '0;
        req_we     = '0;
        req_addr   = '0;
        req_wdata  = '0;
        stall_busy = 1'b0;
        ctl_en     = 1'b1;
        rd_val     = '0;
        repeat (3) @(negedge clk50);
        check_reset_outs("init");
        rst_n = 1'b1;
        repeat (2) @(negedge clk50);

        // Single write from client 0
        set_req(0, 1'b1, 25'h000100, 16'h1234);
        wait_gnt(0, 10, lat);
        check_eq("wr_gnt_lat", lat, 2);
        check_eq("wr_strobe", {read, write, gnt}, {1'b0, 1'b1, 2'b01});
        check_eq("wr_addr", addr, 25'h000100);
        check_eq("wr_wdata", wdata, 16'h1234);
        req = '0;
        @(negedge clk50);
        check_eq("wr_strobe_len", write, 1'b0);
        check_eq("wr_addr_hold", {busy_w, addr, wdata}, {1'b1, 25'h000100, 16'h1234});
        @(negedge clk50);
        check_eq("wr_addr_hold2", {busy_w, addr, wdata}, {1'b1, 25'h000100, 16'h1234});
        base_rsp = n_rsp;
        repeat (8) @(negedge clk50);
        check_eq("wr_no_rsp", n_rsp - base_rsp, 0);

        // Single read from client 1
        rd_val = 16'hBEEF;
        set_req(1, 1'b0, 25'h0000FF, 16'h0000);
        wait_gnt(1, 10, lat);
        check_eq("rd_gnt_lat", lat, 2);
        check_eq("rd_strobe", {read, write, gnt, addr}, {1'b1, 1'b0, 2'b10, 25'h0000FF});
        req = '0;
        wait_rsp(20, lat);
        check_eq("rd_rsp_valid", rsp_valid, 2'b10);
        check_eq("rd_rsp_data", rsp_data, 16'hBEEF);
        check_eq("rd_err", err, 1'b0);
        @(negedge clk50);
        check_eq("rd_rsp_pulse", rsp_valid, 2'b00);
        check_eq("rd_rsp_hold", rsp_data, 16'hBEEF);
        repeat (4) @(negedge clk50);

        // Reset in the middle of a read
        rd_val = 16'h7777;
        set_req(0, 1'b0, 25'h000055, 16'h0000);
        wait_gnt(0, 10, lat);
        check_eq("rst_pre_gnt_lat", lat, 2);
        req = '0;
        @(negedge clk50);
        rst_n    = 1'b0;
        base_rsp = n_rsp;
        base_gnt = gnt_log.size();
        repeat (2) @(negedge clk50);
        check_reset_outs("rst_mid");
        repeat (3) @(negedge clk50);
        rst_n = 1'b1;
        repeat (10) @(negedge clk50);
        check_eq("rst_no_rsp", n_rsp - base_rsp, 0);
        check_eq("rst_no_gnt", gnt_log.size() - base_gnt, 0);
        check_reset_outs("rst_after");
        rd_val = 16'h4242;
        set_req(1, 1'b0, 25'h000077, 16'h0000);
        wait_gnt(1, 10, lat);
        check_eq("rst_next_gnt_lat", lat, 2);
        req = '0;
        wait_rsp(20, lat);
        check_eq("rst_next_rsp", {rsp_valid, rsp_data}, {2'b10, 16'h4242});
        repeat (4) @(negedge clk50);

        // Contention: both clients keep requesting reads
        rd_val = 16'h0A0A;
        gnt_log.delete();
        base_both = n_both;
        base_long = n_long;
        base_rsp  = n_rsp;
        set_req(0, 1'b0, 25'h000010, 16'h0000);
        set_req(1, 1'b0, 25'h000020, 16'h0000);
        for (int i = 0; i < 200 && gnt_log.size() < 6; i++) @(negedge clk50);
        req = '0;
        check_eq("cont_gnt_count", gnt_log.size(), 6);
        for (int i = 0; i < 6 && i < gnt_log.size(); i++)
            check_eq($sformatf("cont_order%0d", i), gnt_log[i], i % 2);
        repeat (12) @(negedge clk50);
        check_eq("cont_overlap", n_both - base_both, 0);
        check_eq("cont_strobe_len", n_long - base_long, 0);
        check_eq("cont_rsp_count", n_rsp - base_rsp, 6);

        // Busy already high in IDLE stalls the next command
        stall_busy = 1'b1;
        base_strb  = n_strb;
        base_gnt   = gnt_log.size();
        set_req(0, 1'b1, 25'h000300, 16'h5A5A);
        repeat (6) @(negedge clk50);
        check_eq("stall_no_strobe", n_strb - base_strb, 0);
        check_eq("stall_no_gnt", gnt_log.size() - base_gnt, 0);
        stall_busy = 1'b0;
        wait_gnt(0, 10, lat);
        check_eq("stall_gnt_lat", lat, 2);
        check_eq("stall_strobe", {read, write, addr}, {1'b0, 1'b1, 25'h000300});
        req = '0;
        repeat (8) @(negedge clk50);

        // Busy never rises: timeout sets sticky err
        ctl_en   = 1'b0;
        base_rsp = n_rsp;
        set_req(0, 1'b0, 25'h000400, 16'h0000);
        wait_gnt(0, 10, lat);
        check_eq("tmo_gnt_lat", lat, 2);
        check_eq("tmo_strobe", read, 1'b1);
        req = '0;
        repeat (14) @(negedge clk50);
        check_eq("tmo_err_early", err, 1'b0);
        @(negedge clk50);
        check_eq("tmo_err_set", err, 1'b1);
        ctl_en = 1'b1;
        set_req(1, 1'b1, 25'h000500, 16'hC0DE);
        wait_gnt(1, 10, lat);
        check_eq("tmo_next_gnt_lat", lat, 2);
        check_eq("tmo_next_strobe", {write, wdata}, {1'b1, 16'hC0DE});
        req = '0;
        repeat (8) @(negedge clk50);
        check_eq("tmo_no_rsp", n_rsp - base_rsp, 0);
        check_eq("tmo_err_sticky", err, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
